// File: rtl/cla_adder_pkg.sv
// Shared definitions for the carry-lookahead adder: group width and the
// group propagate/generate pair.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Collapse four per-bit propagate/generate terms into one group pair.
  function automatic pg_t group_pg(input logic [GROUP_W-1:0] p,
                                   input logic [GROUP_W-1:0] g);
    pg_t r;
    r.p = p[3] & p[2] & p[1] & p[0];
    r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction

endpackage

// File: rtl/cla_adder_cla4.sv
// 4-bit carry-lookahead group: fully expanded internal carries, sum bits,
// and the group propagate/generate pair for the second-level unit.
module cla4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               grp_p,
  output logic               grp_g
);

  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] c;
  pg_t                pg;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is a flat sum of products of cin, so no carry waits on another.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;

  assign pg    = group_pg(p, g);
  assign grp_p = pg.p;
  assign grp_g = pg.g;

endmodule

// File: rtl/cla_adder.sv
// Registered carry-lookahead adder: {cout, sum} = a + b + cin, presented one
// clock after the operands are sampled with in_valid.
module cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 8  // must be a multiple of GROUP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  localparam int NGROUPS = WIDTH / GROUP_W;

  logic [NGROUPS-1:0] grp_p;
  logic [NGROUPS-1:0] grp_g;
  logic [NGROUPS:0]   c;
  logic [WIDTH-1:0]   sum_d;

  for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
    cla4 u_cla4 (
      .a     (a[k*GROUP_W +: GROUP_W]),
      .b     (b[k*GROUP_W +: GROUP_W]),
      .cin   (c[k]),
      .sum   (sum_d[k*GROUP_W +: GROUP_W]),
      .grp_p (grp_p[k]),
      .grp_g (grp_g[k])
    );
  end

  // Second-level lookahead: group P/G never depend on their own carry-in,
  // so this chain only touches group-level signals.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < NGROUPS; k++) begin
      c[k+1] = grp_g[k] | (grp_p[k] & c[k]);
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the async reset clears outputs without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_d;
        cout <= c[NGROUPS];
      end
    end
  end

endmodule

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder: directed corner cases, hold and async
// reset behaviour, then random back-to-back traffic against an arithmetic model.
module tb_cla_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;
  logic       out_valid;

  int total = 0;
  int bad   = 0;

  // Reference state: last accepted result and whether the last cycle was valid.
  logic [7:0] m_sum   = '0;
  logic       m_cout  = 1'b0;
  logic       m_valid = 1'b0;

  cla_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed={v,c,s}=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of operands, update the model, and compare after the edge.
  task automatic step(input logic v, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tc, input string tag);
    logic [8:0] full;
    in_valid = v;
    a        = ta;
    b        = tb;
    cin      = tc;
    @(posedge clk);
    #1;
    if (v) begin
      full    = 9'(ta) + 9'(tb) + 9'(tc);
      m_sum   = full[7:0];
      m_cout  = full[8];
    end
    m_valid = v;
    check(tag, {out_valid, cout, sum}, {m_valid, m_cout, m_sum});
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    #1;
    check("reset_state", {out_valid, cout, sum}, 10'h000);
    @(posedge clk);
    #1;
    check("reset_held_edge", {out_valid, cout, sum}, 10'h000);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 8'h0F, 8'h01, 1'b0, "group_boundary");
    check("group_boundary_lit", {out_valid, cout, sum}, 10'h210);
    step(1'b1, 8'hFF, 8'h01, 1'b0, "full_propagate");
    check("full_propagate_lit", {out_valid, cout, sum}, 10'h300);
    step(1'b1, 8'h05, 8'hFC, 1'b1, "sub_5_3");
    check("sub_5_3_lit", {out_valid, cout, sum}, 10'h302);
    step(1'b1, 8'h03, 8'hFA, 1'b1, "sub_3_5_borrow");
    check("sub_3_5_lit", {out_valid, cout, sum}, 10'h2FE);
    step(1'b1, 8'hFF, 8'hFF, 1'b1, "max_plus_max");
    check("max_plus_max_lit", {out_valid, cout, sum}, 10'h3FF);
    step(1'b0, 8'h12, 8'h34, 1'b0, "hold_1");
    check("hold_1_lit", {out_valid, cout, sum}, 10'h1FF);
    step(1'b0, 8'h00, 8'h00, 1'b1, "hold_2");
    check("hold_2_lit", {out_valid, cout, sum}, 10'h1FF);

    // Async reset between edges while a valid result is on the outputs.
    step(1'b1, 8'h3C, 8'h5A, 1'b1, "pre_reset");
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {out_valid, cout, sum}, 10'h000);
    m_sum   = '0;
    m_cout  = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    check("reset_midcycle_hold", {out_valid, cout, sum}, 10'h000);
    rst_n = 1'b1;

    step(1'b1, 8'h80, 8'h80, 1'b0, "post_reset_first");
    check("post_reset_first_lit", {out_valid, cout, sum}, 10'h300);
    step(1'b1, 8'h00, 8'h00, 1'b0, "zero_zero");
    step(1'b1, 8'h00, 8'h00, 1'b1, "zero_cin");
    step(1'b1, 8'hF0, 8'h0F, 1'b1, "all_propagate_cin");

    // Back-to-back random traffic with occasional idle cycles.
    for (int i = 0; i < 20000; i++) begin
      step(($urandom_range(0, 7) != 0), 8'($urandom), 8'($urandom), 1'($urandom),
           "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
